// File: rtl/cf_fft_pkg.sv
// Shared types and helpers for the 1024-point FFT unloader: size defaults, sample type,
// FSM state encodings and the index bit-reversal used for reordering.
package cf_fft_pkg;

  localparam int LOG2N_DEF = 10;
  localparam int W_DEF     = 16;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } sample_t;

  typedef enum logic { WIDLE, FILL  } wstate_t;
  typedef enum logic { RIDLE, DRAIN } rstate_t;

  // Reverse the low n bits of a (n <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] a, input int n);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = a[i];
    return r >> (16 - n);
  endfunction

endpackage

// File: rtl/cf_fft_1024_8_unload_ram.sv
// Ping-pong sample store: simple dual-port RAM, one write port and one registered read port.
module cf_fft_1024_8_unload_ram
  import cf_fft_pkg::*;
#(
  parameter int AW = LOG2N_DEF + 1,
  parameter int DW = 2 * W_DEF
) (
  input  logic          clock_c,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock_c) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cf_fft_1024_8_unload.sv
// FFT output unloader: captures a frame into a ping-pong buffer and replays it with its own sync.
// Build option CF_FFT_UNLOAD_BITREV_EN: bit-reversed write addressing (natural-order output).
module cf_fft_1024_8_unload
  import cf_fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int W     = W_DEF
) (
  input  logic                clock_c,
  input  logic                i5,
  input  logic                i1,
  input  logic signed [W-1:0] i2,
  input  logic signed [W-1:0] i3,
  input  logic                i4,
  output logic                o1,
  output logic signed [W-1:0] o2,
  output logic signed [W-1:0] o3
);

  localparam logic [LOG2N-1:0] LAST = '1;

  wstate_t          wstate_q, wstate_d;
  rstate_t          rstate_q, rstate_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic             wbank_q, wbank_d, rbank_q, rbank_d;
  logic [1:0]       full_q, full_d;
  logic             wreq, wdone, rd_go, rel;
  logic [LOG2N-1:0] widx, waddr_p0;
  logic             vld_p1, sof_p1;
  logic [2*W-1:0]   rdata_p1;

  // Write side: i1 always (re)starts a frame at index 0 in the current bank.
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    wreq     = 1'b0;
    wdone    = 1'b0;
    widx     = '0;
    if (i1) begin
      wreq     = 1'b1;
      wcnt_d   = LOG2N'(1);
      wstate_d = FILL;
    end else if (wstate_q == FILL) begin
      wreq   = 1'b1;
      widx   = wcnt_q;
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST) begin
        wdone    = 1'b1;
        wbank_d  = !wbank_q;
        wstate_d = WIDLE;
      end
    end
  end

`ifdef CF_FFT_UNLOAD_BITREV_EN
  assign waddr_p0 = LOG2N'(bitrev(16'(widx), LOG2N));
`else
  assign waddr_p0 = widx;
`endif

  // Read side: a release chains straight into the other bank when it is already full.
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    rd_go    = 1'b0;
    rel      = 1'b0;
    case (rstate_q)
      RIDLE: begin
        if (full_q[rbank_q]) begin
          rstate_d = DRAIN;
          rcnt_d   = '0;
        end
      end
      DRAIN: begin
        rd_go  = 1'b1;
        rcnt_d = rcnt_q + 1'b1;
        if (rcnt_q == LAST) begin
          rel      = 1'b1;
          rbank_d  = !rbank_q;
          rstate_d = full_q[!rbank_q] ? DRAIN : RIDLE;
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (rel)   full_d[rbank_q] = 1'b0;
    if (wdone) full_d[wbank_q] = 1'b1;
  end

  always_ff @(posedge clock_c) begin
    if (i5) begin
      wstate_q <= WIDLE;
      rstate_q <= RIDLE;
      wcnt_q   <= '0;
      rcnt_q   <= '0;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b0;
      full_q   <= '0;
    end else if (i4) begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      full_q   <= full_d;
    end
  end

  // Stage p0 -> p1: synchronous RAM read, with its valid/sync travelling alongside.
  cf_fft_1024_8_unload_ram #(
    .AW (LOG2N + 1),
    .DW (2 * W)
  ) u_ram (
    .clock_c (clock_c),
    .we      (i4 && wreq),
    .waddr   ({wbank_q, waddr_p0}),
    .wdata   ({i2, i3}),
    .re      (i4),
    .raddr   ({rbank_q, rcnt_q}),
    .rdata   (rdata_p1)
  );

  always_ff @(posedge clock_c) begin
    if (i5) begin
      vld_p1 <= 1'b0;
      sof_p1 <= 1'b0;
    end else if (i4) begin
      vld_p1 <= rd_go;
      sof_p1 <= rd_go && (rcnt_q == '0);
    end
  end

  // Stage p1 -> output register: data is forced to zero outside a drain.
  always_ff @(posedge clock_c) begin
    if (i5) begin
      o1 <= 1'b0;
      o2 <= '0;
      o3 <= '0;
    end else if (i4) begin
      o1 <= vld_p1 && sof_p1;
      o2 <= vld_p1 ? $signed(rdata_p1[2*W-1:W]) : '0;
      o3 <= vld_p1 ? $signed(rdata_p1[W-1:0])   : '0;
    end
  end

  // A write landing in a still-full bank means the write bank swapped onto a draining bank.
  assert property (@(posedge clock_c) disable iff (i5)
    !(i4 && wreq && full_q[wbank_q] && !(rel && (rbank_q == wbank_q))));

endmodule

// File: tb/tb_cf_fft_1024_8_unload.sv
// Scoreboard bench for cf_fft_1024_8_unload: a frame-level model schedules every expected
// output sample by enabled-cycle number; a monitor pops and compares each cycle.
module tb_cf_fft_1024_8_unload;

  localparam int N = 1024;

  logic        clock_c = 1'b0;
  logic        i5 = 1'b1, i1 = 1'b0, i4 = 1'b0;
  logic [15:0] i2 = '0, i3 = '0;
  logic        o1;
  logic [15:0] o2, o3;

  always #5 clock_c = ~clock_c;

  cf_fft_1024_8_unload dut (
    .clock_c (clock_c),
    .i5      (i5),
    .i1      (i1),
    .i2      (i2),
    .i3      (i3),
    .i4      (i4),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3)
  );

  typedef struct {
    int          due;
    logic        sync;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] part[$];
  bit          filling = 0;
  bit          armed   = 0;
  int          kind    = 0;   // 0: stalled edge, 1: enabled edge, 2: reset edge
  int          ecnt    = 0;
  int          next_free = 0;
  int          errors  = 0;
  int          checks  = 0;

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < 10; i++) if (((v >> i) & 1) != 0) r += 1 << (9 - i);
    return r;
  endfunction

  // Input index whose sample appears at output position n.
  function automatic int src_index(input int n);
`ifdef CF_FFT_UNLOAD_BITREV_EN
    return brev(n);
`else
    return n;
`endif
  endfunction

  // A completed frame plays out 3 enabled cycles later, or right after the previous one.
  task automatic schedule_frame();
    int   start;
    exp_t e;
    start = (ecnt + 3 > next_free) ? ecnt + 3 : next_free;
    for (int n = 0; n < N; n++) begin
      e.due  = start + n;
      e.sync = (n == 0);
      e.re   = part[src_index(n)][31:16];
      e.im   = part[src_index(n)][15:0];
      exp_q.push_back(e);
    end
    next_free = start + N;
    part.delete();
    filling = 0;
  endtask

  task automatic step(input bit rst, input bit en, input bit sync,
                      input logic [15:0] re, input logic [15:0] im);
    i5 = rst; i4 = en; i1 = sync; i2 = re; i3 = im;
    @(posedge clock_c);
    if (rst) begin
      exp_q.delete();
      part.delete();
      filling   = 0;
      next_free = 0;
      kind      = 2;
      armed     = 1;
    end else if (en) begin
      ecnt++;
      kind = 1;
      if (sync) begin
        part.delete();
        filling = 1;
      end
      if (filling) part.push_back({re, im});
      if (filling && part.size() == N) schedule_frame();
    end else begin
      kind = 0;
    end
    #1;
  endtask

  task automatic maybe_stall(input bit stall);
    while (stall && $urandom_range(0, 99) < 30)
      step(0, 0, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic idle(input int n, input bit stall);
    for (int j = 0; j < n; j++) begin
      maybe_stall(stall);
      step(0, 1, 0, 16'($urandom), 16'($urandom));
    end
  endtask

  // pattern=1: sample k carries bitrev(k) (or k in pass-through builds) so output is 0..N-1.
  task automatic send_frame(input bit stall, input bit pattern);
    logic [15:0] re;
    for (int k = 0; k < N; k++) begin
      maybe_stall(stall);
      re = pattern ? 16'(src_index(k)) : 16'($urandom);
      step(0, 1, (k == 0), re, pattern ? ~re : 16'($urandom));
    end
  endtask

  initial begin : monitor
    exp_t cur, zero;
    zero.due = 0; zero.sync = 0; zero.re = '0; zero.im = '0;
    cur = zero;
    forever begin
      @(negedge clock_c);
      if (armed) begin
        if (kind == 1) begin
          if (exp_q.size() > 0 && exp_q[0].due == ecnt) cur = exp_q.pop_front();
          else cur = zero;
        end else if (kind == 2) begin
          cur = zero;
        end
        checks++;
        if ({o1, o2, o3} !== {cur.sync, cur.re, cur.im}) begin
          errors++;
          $display("FAIL output e%0d: got o1=%0b o2=%h o3=%h, want o1=%0b o2=%h o3=%h",
                   ecnt, o1, o2, o3, cur.sync, cur.re, cur.im);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held with live, random inputs, then a long quiet stretch with no sync.
    for (int j = 0; j < 8; j++) step(1, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
    idle(1030, 0);

    send_frame(0, 1);
    idle(1030, 0);

    repeat (3) send_frame(0, 0);
    idle(1030, 0);

    send_frame(1, 1);
    idle(1030, 1);

    // Restart: abandon a partial frame at k=500 with a fresh sync.
    for (int k = 0; k < 500; k++) step(0, 1, (k == 0), 16'($urandom), 16'($urandom));
    send_frame(0, 0);
    idle(1030, 0);

    // Reset right after output sample 300 has been presented, then a clean frame.
    send_frame(0, 0);
    idle(303, 0);
    step(1, 1, 0, 16'($urandom), 16'($urandom));
    send_frame(0, 1);
    idle(1030, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_complete: %0d expected samples never appeared, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
